// File: rtl/axi4lite_req_master_if.sv
// AXI4-lite bus bundle with clock/reset; master and slave views.
// ALEN (address width) defaults to 32 when not defined externally.
`ifndef ALEN
`define ALEN 32
`endif

interface axi4lite (
  input logic aclk,
  input logic aresetn
);
  logic [`ALEN-1:0] awaddr;
  logic [2:0]       awprot;
  logic             awvalid;
  logic             awready;
  logic [63:0]      wdata;
  logic [7:0]       wstrb;
  logic             wvalid;
  logic             wready;
  logic [1:0]       bresp;
  logic             bvalid;
  logic             bready;
  logic [`ALEN-1:0] araddr;
  logic [2:0]       arprot;
  logic             arvalid;
  logic             arready;
  logic [63:0]      rdata;
  logic [1:0]       rresp;
  logic             rvalid;
  logic             rready;

  modport master (
    input  aclk, aresetn,
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    input  aclk, aresetn,
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi4lite_req_master.sv
// Single-outstanding AXI4-lite initiator behind a valid/ready request port.
// Option: AXI4LITE_REQ_MASTER_ALIGN_CHECK_EN rejects misaligned requests locally.
`ifndef ALEN
`define ALEN 32
`endif

module axi4lite_req_master #(
  parameter logic [`ALEN-1:0] ADDR_MASK = {`ALEN{1'b1}}
) (
  axi4lite.master          bus,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [`ALEN-1:0] req_addr,
  input  logic [63:0]      req_wdata,
  input  logic [7:0]       req_wstrb,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_write,
  output logic [63:0]      rsp_rdata,
  output logic [1:0]       rsp_resp
);

  typedef enum logic [2:0] {
    IDLE, WR, WB, RA, RD, RSP
  } state_t;

  state_t           state_q, state_d;
  logic             req_ready_d;
  logic             awvalid_q, awvalid_d;
  logic             wvalid_q, wvalid_d;
  logic             bready_q, bready_d;
  logic             arvalid_q, arvalid_d;
  logic             rready_q, rready_d;
  logic [`ALEN-1:0] addr_q, addr_d;
  logic [63:0]      wdata_q, wdata_d;
  logic [7:0]       wstrb_q, wstrb_d;
  logic             rsp_valid_d;
  logic             rsp_write_d;
  logic [63:0]      rsp_rdata_d;
  logic [1:0]       rsp_resp_d;

`ifdef AXI4LITE_REQ_MASTER_ALIGN_CHECK_EN
  localparam logic [1:0] AXI4LITE_RESP_SLVERR = 2'b10;
  logic misaligned;
  assign misaligned = |req_addr[2:0];
`endif

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = rsp_valid;
    rsp_write_d = rsp_write;
    rsp_rdata_d = rsp_rdata;
    rsp_resp_d  = rsp_resp;
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          addr_d      = req_addr & ADDR_MASK;
          wdata_d     = req_wdata;
          wstrb_d     = req_wstrb;
          req_ready_d = 1'b0;
`ifdef AXI4LITE_REQ_MASTER_ALIGN_CHECK_EN
          if (misaligned) begin
            state_d     = RSP;
            rsp_valid_d = 1'b1;
            rsp_write_d = req_write;
            rsp_rdata_d = '0;
            rsp_resp_d  = AXI4LITE_RESP_SLVERR;
          end else
`endif
          if (req_write) begin
            state_d   = WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RA;
            arvalid_d = 1'b1;
          end
        end
      end
      WR: begin
        if (awvalid_q && bus.awready) awvalid_d = 1'b0;
        if (wvalid_q && bus.wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = WB;
          bready_d = 1'b1;
        end
      end
      WB: begin
        if (bus.bvalid && bready_q) begin
          state_d     = RSP;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = bus.bresp;
        end
      end
      RA: begin
        if (bus.arready) begin
          state_d   = RD;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      RD: begin
        if (bus.rvalid && rready_q) begin
          state_d     = RSP;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = bus.rdata;
          rsp_resp_d  = bus.rresp;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge bus.aclk) begin
    if (!bus.aresetn) begin
      state_q   <= IDLE;
      req_ready <= 1'b1;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= '0;
    end else begin
      state_q   <= state_d;
      req_ready <= req_ready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rsp_valid <= rsp_valid_d;
      rsp_write <= rsp_write_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_resp  <= rsp_resp_d;
    end
  end

  // Address is shared by both channels; only one is ever valid.
  assign bus.awaddr  = addr_q;
  assign bus.araddr  = addr_q;
  assign bus.awprot  = 3'b000;
  assign bus.arprot  = 3'b000;
  assign bus.awvalid = awvalid_q;
  assign bus.wvalid  = wvalid_q;
  assign bus.wdata   = wdata_q;
  assign bus.wstrb   = wstrb_q;
  assign bus.bready  = bready_q;
  assign bus.arvalid = arvalid_q;
  assign bus.rready  = rready_q;

endmodule

// File: tb/tb_axi4lite_req_master.sv
// Directed bench for axi4lite_req_master; slave side scripted step by step.
`ifndef ALEN
`define ALEN 32
`endif

module tb_axi4lite_req_master;

  logic aclk = 1'b0;
  logic aresetn;

  always #5 aclk = ~aclk;

  axi4lite bus (.aclk(aclk), .aresetn(aresetn));

  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [`ALEN-1:0] req_addr;
  logic [63:0]      req_wdata;
  logic [7:0]       req_wstrb;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_write;
  logic [63:0]      rsp_rdata;
  logic [1:0]       rsp_resp;

  axi4lite_req_master dut (
    .bus       (bus),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_write (rsp_write),
    .rsp_rdata (rsp_rdata),
    .rsp_resp  (rsp_resp)
  );

  int vectors = 0;
  int miscompares = 0;
  int b_hs = 0;
  int ar_hs = 0;

  always @(posedge aclk) begin
    if (bus.bvalid && bus.bready) b_hs++;
    if (bus.arvalid && bus.arready) ar_hs++;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic issue(input logic w,
                       input logic [`ALEN-1:0] a,
                       input logic [63:0] d,
                       input logic [7:0] s);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_wstrb = s;
    step();
    req_valid = 1'b0;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("consume_rsp_valid", rsp_valid, 0);
    chk("consume_req_ready", req_ready, 1);
  endtask

  initial begin
    aresetn     = 1'b0;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;
    req_wstrb   = '0;
    rsp_ready   = 1'b0;
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    bus.bresp   = 2'b00;
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rdata   = '0;
    bus.rresp   = 2'b00;
    step();
    step();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_awvalid", bus.awvalid, 0);
    chk("rst_wvalid", bus.wvalid, 0);
    chk("rst_arvalid", bus.arvalid, 0);
    chk("rst_bready", bus.bready, 0);
    chk("rst_rready", bus.rready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_resp", rsp_resp, 0);
    aresetn = 1'b1;
    step();

    // zero-wait write
    bus.awready = 1'b1;
    bus.wready  = 1'b1;
    issue(1'b1, 32'h8, 64'h0100, 8'h03);
    chk("w1_req_ready", req_ready, 0);
    chk("w1_awvalid", bus.awvalid, 1);
    chk("w1_wvalid", bus.wvalid, 1);
    chk("w1_awaddr", bus.awaddr, 64'h8);
    chk("w1_wstrb", bus.wstrb, 64'h03);
    chk("w1_wdata", bus.wdata, 64'h0100);
    step();
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    chk("w1_awvalid_drop", bus.awvalid, 0);
    chk("w1_wvalid_drop", bus.wvalid, 0);
    chk("w1_bready", bus.bready, 1);
    bus.bvalid = 1'b1;
    bus.bresp  = 2'b00;
    step();
    bus.bvalid = 1'b0;
    chk("w1_bready_off", bus.bready, 0);
    chk("w1_rsp_valid", rsp_valid, 1);
    chk("w1_rsp_write", rsp_write, 1);
    chk("w1_rsp_resp", rsp_resp, 0);
    chk("w1_rsp_rdata", rsp_rdata, 0);
    consume();

    // read with 3 wait cycles on arready
    issue(1'b0, 32'h0, 64'h0, 8'h00);
    chk("r1_arvalid", bus.arvalid, 1);
    chk("r1_araddr", bus.araddr, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("r1_arvalid_hold", bus.arvalid, 1);
    end
    bus.arready = 1'b1;
    step();
    bus.arready = 1'b0;
    chk("r1_arvalid_drop", bus.arvalid, 0);
    chk("r1_rready", bus.rready, 1);
    bus.rvalid = 1'b1;
    bus.rdata  = 64'hDEAD_BEEF;
    bus.rresp  = 2'b00;
    step();
    bus.rvalid = 1'b0;
    chk("r1_rready_off", bus.rready, 0);
    chk("r1_rsp_valid", rsp_valid, 1);
    chk("r1_rsp_write", rsp_write, 0);
    chk("r1_rsp_rdata", rsp_rdata, 64'hDEAD_BEEF);
    chk("r1_rsp_resp", rsp_resp, 0);
    consume();

    // write: awready two cycles ahead of wready, bvalid held long
    b_hs = 0;
    issue(1'b1, 32'h20, 64'h1122_3344_5566_7788, 8'hFF);
    bus.awready = 1'b1;
    step();
    bus.awready = 1'b0;
    chk("w2_awvalid_drop", bus.awvalid, 0);
    chk("w2_wvalid_hold", bus.wvalid, 1);
    chk("w2_bready_wait", bus.bready, 0);
    step();
    chk("w2_wvalid_hold2", bus.wvalid, 1);
    chk("w2_wdata", bus.wdata, 64'h1122_3344_5566_7788);
    bus.wready = 1'b1;
    step();
    bus.wready = 1'b0;
    chk("w2_wvalid_drop", bus.wvalid, 0);
    chk("w2_bready", bus.bready, 1);
    bus.bvalid = 1'b1;
    step();
    step();
    bus.bvalid = 1'b0;
    chk("w2_b_handshakes", b_hs, 1);
    chk("w2_rsp_valid", rsp_valid, 1);
    chk("w2_rsp_resp", rsp_resp, 0);
    consume();

    // read SLVERR with response back-pressure
    issue(1'b0, 32'h10, 64'h0, 8'h00);
    chk("r2_araddr", bus.araddr, 64'h10);
    bus.arready = 1'b1;
    step();
    bus.arready = 1'b0;
    bus.rvalid  = 1'b1;
    bus.rdata   = 64'h1234;
    bus.rresp   = 2'b10;
    step();
    bus.rvalid = 1'b0;
    chk("r2_rsp_valid", rsp_valid, 1);
    chk("r2_rsp_resp", rsp_resp, 2);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("r2_hold_valid", rsp_valid, 1);
      chk("r2_hold_resp", rsp_resp, 2);
      chk("r2_hold_rdata", rsp_rdata, 64'h1234);
      chk("r2_hold_req_ready", req_ready, 0);
    end
    consume();

    // reset while waiting for rdata
    issue(1'b0, 32'h18, 64'h0, 8'h00);
    bus.arready = 1'b1;
    step();
    bus.arready = 1'b0;
    chk("r3_rready", bus.rready, 1);
    aresetn = 1'b0;
    step();
    aresetn = 1'b1;
    chk("r3_rst_rready", bus.rready, 0);
    chk("r3_rst_arvalid", bus.arvalid, 0);
    chk("r3_rst_req_ready", req_ready, 1);
    chk("r3_rst_rsp_valid", rsp_valid, 0);
    bus.rvalid = 1'b1;
    bus.bvalid = 1'b1;
    step();
    step();
    bus.rvalid = 1'b0;
    bus.bvalid = 1'b0;
    chk("r3_spurious_rsp", rsp_valid, 0);
    chk("r3_spurious_req_ready", req_ready, 1);

    // misaligned read
    ar_hs = 0;
    issue(1'b0, 32'h3, 64'h0, 8'h00);
`ifdef AXI4LITE_REQ_MASTER_ALIGN_CHECK_EN
    chk("r4_no_arvalid", bus.arvalid, 0);
    chk("r4_rsp_valid", rsp_valid, 1);
    chk("r4_rsp_resp", rsp_resp, 2);
    chk("r4_rsp_write", rsp_write, 0);
    chk("r4_rsp_rdata", rsp_rdata, 0);
    bus.arready = 1'b1;
    step();
    bus.arready = 1'b0;
    chk("r4_no_ar_hs", ar_hs, 0);
    consume();
`else
    chk("r4_arvalid", bus.arvalid, 1);
    chk("r4_araddr", bus.araddr, 64'h3);
    bus.arready = 1'b1;
    step();
    bus.arready = 1'b0;
    chk("r4_ar_hs", ar_hs, 1);
    bus.rvalid = 1'b1;
    bus.rdata  = 64'h55;
    bus.rresp  = 2'b00;
    step();
    bus.rvalid = 1'b0;
    chk("r4_rsp_valid", rsp_valid, 1);
    chk("r4_rsp_rdata", rsp_rdata, 64'h55);
    chk("r4_rsp_resp", rsp_resp, 0);
    consume();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
